// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access-size encodings, LSU state type and
// lane helpers used by the load/store unit and its alignment datapath.
package riscv_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;   // executes as a word access

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } lsu_state_t;

   // Byte lane an access starts on once the offset is truncated to its natural alignment.
   function automatic logic [1:0] aligned_lane(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_BYTE: return offset;
         SIZE_HALF: return {offset[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

   // True when the address offset is not naturally aligned for the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return offset[0];
         default:   return (offset != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Load alignment: selects the addressed byte/half lane from a memory word
// and zero- or sign-extends it to 32 bits.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane extraction followed by extension according to the access size.
   always_comb begin
      case (lane)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SIZE_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         SIZE_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
         default:   data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time, issues a single
// word-aligned memory request, aligns load data and returns a result.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// complete immediately with out_err instead of being forced aligned).
module load_store_unit
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [2:0]  in_load_size,
   input  logic [1:0]  in_store_size,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_reg_write,
   output logic [4:0]  out_rd,
   output logic [31:0] out_data,
   output logic        out_err,
   input  logic        flush
);

   lsu_state_t  state;
   logic        is_load;
   logic        drop;
   logic [1:0]  ld_size;
   logic        ld_sign;
   logic [1:0]  ld_lane;
   logic [31:0] align_data;

   logic        iss_load;
   logic        iss_cmd;
   logic [1:0]  iss_size;
   logic [1:0]  iss_lane;
   logic [3:0]  iss_strb;
   logic [31:0] iss_wdata;
   logic        iss_trap;

   // Issue-side preparation: size selection, forced alignment, strobes and lane replication.
   always_comb begin
      iss_load  = in_mem_read;
      iss_cmd   = in_mem_read | in_mem_write;
      iss_size  = iss_load ? in_load_size[1:0] : in_store_size;
      iss_lane  = aligned_lane(iss_size, in_addr[1:0]);
      iss_strb  = '1;
      iss_wdata = in_wdata;
      case (iss_size)
         SIZE_BYTE: begin
            iss_strb  = 4'b0001 << iss_lane;
            iss_wdata = {4{in_wdata[7:0]}};
         end
         SIZE_HALF: begin
            iss_strb  = 4'b0011 << iss_lane;
            iss_wdata = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
      if (iss_load) iss_strb = '0;
`ifdef LSU_MISALIGN_TRAP_EN
      iss_trap = misaligned(iss_size, in_addr[1:0]);
`else
      iss_trap = 1'b0;
`endif
   end

   lsu_align u_align (
      .rdata    (mem_rdata),
      .lane     (ld_lane),
      .size     (ld_size),
      .sign_ext (ld_sign),
      .data     (align_data)
   );

`ifndef LSU_MISALIGN_TRAP_EN
   assign out_err = 1'b0;
`endif

   // Control FSM with all handshake and result outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         drop          <= 1'b0;
         is_load       <= 1'b0;
         ld_size       <= '0;
         ld_sign       <= 1'b0;
         ld_lane       <= '0;
         in_ready      <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wstrb     <= '0;
         out_valid     <= 1'b0;
         out_reg_write <= 1'b0;
         out_rd        <= '0;
         out_data      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         out_err       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               // Commands with neither read nor write are consumed without effect.
               if (in_valid && !flush && iss_cmd) begin
                  is_load       <= iss_load;
                  ld_size       <= iss_size;
                  ld_sign       <= in_load_size[2];
                  ld_lane       <= iss_lane;
                  out_rd        <= in_rd;
                  out_data      <= '0;
                  in_ready      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                  out_err       <= iss_trap;
`endif
                  if (iss_trap) begin
                     state         <= S_RESP;
                     out_valid     <= 1'b1;
                     out_reg_write <= 1'b0;
                  end else begin
                     state         <= S_REQ;
                     mem_req_valid <= 1'b1;
                     mem_we        <= ~iss_load;
                     mem_addr      <= {in_addr[31:2], 2'b00};
                     mem_wdata     <= iss_wdata;
                     mem_wstrb     <= iss_strb;
                     out_reg_write <= iss_load;
                  end
               end
            end
            S_REQ: begin
               if (flush) begin
                  state         <= S_IDLE;
                  mem_req_valid <= 1'b0;
                  mem_wstrb     <= '0;
                  in_ready      <= 1'b1;
               end else if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_wstrb     <= '0;
                  if (is_load) begin
                     state <= S_WAIT;
                  end else begin
                     state     <= S_RESP;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               // A flushed load still has to absorb its response before the unit is free.
               if (mem_rvalid) begin
                  drop <= 1'b0;
                  if (drop || flush) begin
                     state    <= S_IDLE;
                     in_ready <= 1'b1;
                  end else begin
                     state     <= S_RESP;
                     out_valid <= 1'b1;
                     out_data  <= align_data;
                  end
               end else if (flush) begin
                  drop <= 1'b1;
               end
            end
            S_RESP: begin
               if (flush || out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous reset, active-high.
REQ-002 SHALL have issue ports: in_valid in 1; in_ready out 1; in_mem_read in 1; in_mem_write in 1; in_load_size in 3 (bit2 signed, [1:0] 00 byte/01 half/10 word); in_store_size in 2 (same [1:0] code); in_addr in 32; in_wdata in 32; in_rd in 5.
REQ-003 SHALL have memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_we out 1; mem_addr out 32 (word-aligned, [1:0]=0); mem_wdata out 32 (lane-shifted); mem_wstrb out 4; mem_rvalid in 1; mem_rdata in 32.
REQ-004 SHALL have result ports: out_valid out 1; out_ready in 1; out_reg_write out 1 (1 for loads only); out_rd out 5; out_data out 32; out_err out 1; flush in 1.

Function
REQ-005 SHALL implement FSM IDLE, REQ, WAIT, RESP; in_ready=1 only in IDLE.
REQ-006 IDLE: in_valid with exactly one of in_mem_read/in_mem_write captures all in_* and moves to REQ; in_valid with neither is accepted and dropped; both set is accepted, treated as load.
REQ-007 REQ: mem_req_valid=1 with stable mem_we/addr/wdata/wstrb until mem_req_ready; on handshake load->WAIT, store->RESP.
REQ-008 WAIT: on mem_rvalid, select lane by addr[1:0], zero/sign-extend per load_size, register into out_data, move to RESP; mem_rvalid outside WAIT ignored.
REQ-009 RESP: out_valid=1, outputs stable until out_ready; on handshake return to IDLE; no new issue accepted in the same cycle.
REQ-010 Store strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; wdata replicated/shifted into active lanes.
REQ-011 Minimum load latency with zero-wait memory: issue cycle N, mem_req_valid N+1, mem_rvalid N+2, out_valid N+3; store out_valid N+2.
REQ-012 flush in IDLE/REQ/RESP: return to IDLE next cycle, no out_valid, no memory request issued after flush cycle.
REQ-013 flush in WAIT: set drop flag, stay in WAIT until mem_rvalid, discard data, go to IDLE; flush concurrent with mem_rvalid also discards.
REQ-014 Reserved size code 11 SHALL be treated as word.

Reset
REQ-015 rst SHALL force IDLE, clear drop flag, and drive in_ready=1 (IDLE), mem_req_valid=0, out_valid=0, out_err=0, out_data=0, out_rd=0, out_reg_write=0, mem_wstrb=0 next cycle.
REQ-016 rst during WAIT SHALL abandon the outstanding response; a later stray mem_rvalid in IDLE is ignored.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 skips REQ/WAIT, goes to RESP with out_err=1, out_reg_write=0, out_data=0.
REQ-018 Undefined -> out_err tied 0; misaligned address SHALL be forced aligned (addr[1:0] truncated per size) and executed normally.

Structure
REQ-019 Shared package riscv_pkg SHALL hold load-size/store-size encoding constants and lsu_state_t enum.
REQ-020 Lane select and sign/zero extension SHALL live in combinational sub-module lsu_align.

Verification
REQ-021 lw addr 0x100, mem_rdata 0xDEADBEEF, zero-wait -> out_valid at N+3, out_data 0xDEADBEEF, out_reg_write=1.
REQ-022 lb addr 0x103, mem_rdata 0x80FF0011 -> out_data 0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x102 -> 0xFFFF80FF.
REQ-023 sb addr 0x201, wdata 0xAB -> mem_wstrb 0010, mem_wdata[15:8]=0xAB, mem_addr 0x200, out_reg_write=0.
REQ-024 mem_req_ready low 3 cycles, out_ready low 2 cycles -> request and result held stable, in_ready=0 throughout.
REQ-025 flush in WAIT, mem_rvalid 2 cycles later -> no out_valid, in_ready=1 cycle after rvalid.
REQ-026 With LSU_MISALIGN_TRAP_EN, lw addr 0x102 -> no mem_req_valid, out_err=1 at N+1.
